// File: rtl/csr_defs.sv
// CSR numbering, timer field positions and the masked-write helper.
// Imported by the csr block and the timer/counter unit.
// Pure definitions; no logic, no state.
package csr_defs;

  // Core CSR numbers
  localparam logic [13:0] CSR_CRMD   = 14'h000;
  localparam logic [13:0] CSR_PRMD   = 14'h001;
  localparam logic [13:0] CSR_ECFG   = 14'h004;
  localparam logic [13:0] CSR_ESTAT  = 14'h005;
  localparam logic [13:0] CSR_ERA    = 14'h006;
  localparam logic [13:0] CSR_BADV   = 14'h007;
  localparam logic [13:0] CSR_EENTRY = 14'h00C;
  localparam logic [13:0] CSR_SAVE0  = 14'h030;
  localparam logic [13:0] CSR_SAVE1  = 14'h031;
  localparam logic [13:0] CSR_SAVE2  = 14'h032;
  localparam logic [13:0] CSR_SAVE3  = 14'h033;

  // Timer CSR numbers
  localparam logic [13:0] CSR_TID    = 14'h040;
  localparam logic [13:0] CSR_TCFG   = 14'h041;
  localparam logic [13:0] CSR_TVAL   = 14'h042;
  localparam logic [13:0] CSR_TICLR  = 14'h044;

  // TCFG fields: En, Periodic, InitVal[31:2]
  localparam int TCFG_EN          = 0;
  localparam int TCFG_PERIODIC    = 1;
  localparam int TCFG_INITVAL_LSB = 2;

  // TICLR bit that acknowledges the timer interrupt
  localparam int TICLR_CLR = 0;

  // Bits selected by mask take the new value, the rest keep the old one
  function automatic logic [31:0] csr_masked_wr(input logic [31:0] old_val,
                                                input logic [31:0] mask,
                                                input logic [31:0] value);
    return (mask & value) | (~mask & old_val);
  endfunction

endpackage

// File: rtl/stable_counter.sv
// 64-bit free-running stable counter, exposed as two 32-bit halves.
// Latency: value advances by one every clk; halves come from one register.
// No backpressure; not writable, wraps to zero after all-ones.
module stable_counter (
  input  logic        clk,
  input  logic        resetn,
  output logic [31:0] cnt_lo,
  output logic [31:0] cnt_hi
);

  logic [63:0] cnt_q;
  logic [63:0] cnt_d;

  // Next value is always current + 1; natural 64-bit wrap
  always_comb begin
    cnt_d = cnt_q + 64'd1;
  end

  // Counter register, cleared by async reset
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_lo = cnt_q[31:0];
  assign cnt_hi = cnt_q[63:32];

endmodule

// File: rtl/csr_timer.sv
// Constant timer (TID/TCFG/TVAL/TICLR) plus stable counter for the CSR file.
// Latency: writes visible on reads next cycle; reads are combinational.
// No backpressure: writes always accepted, timer_int held until TICLR clear.
module csr_timer
  import csr_defs::*;
#(
  parameter logic [31:0] CORE_ID = 32'h0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        csr_we,
  input  logic [13:0] csr_wr_num,
  input  logic [31:0] csr_wr_mask,
  input  logic [31:0] csr_wr_value,
  input  logic [13:0] csr_rd_num,
  output logic        csr_rd_hit,
  output logic [31:0] csr_rd_value,
  output logic        timer_int,
  output logic [31:0] cnt_lo,
  output logic [31:0] cnt_hi
);

  logic [31:0] tid_q,  tid_d;
  logic [31:0] tcfg_q, tcfg_d;
  logic [31:0] tval_q, tval_d;
  logic        tint_q, tint_d;

  logic wr_tid, wr_tcfg, wr_ticlr;
  logic tcfg_en, tcfg_periodic;
  logic tint_set, tint_clr;

  assign wr_tid   = csr_we && (csr_wr_num == CSR_TID);
  assign wr_tcfg  = csr_we && (csr_wr_num == CSR_TCFG);
  assign wr_ticlr = csr_we && (csr_wr_num == CSR_TICLR);

  assign tcfg_en       = tcfg_q[TCFG_EN];
  assign tcfg_periodic = tcfg_q[TCFG_PERIODIC];

  // Interrupt: set when an enabled timer sits at zero, cleared by TICLR; set wins
  assign tint_set = tcfg_en && (tval_q == 32'h0);
  assign tint_clr = wr_ticlr && csr_wr_mask[TICLR_CLR] && csr_wr_value[TICLR_CLR];

  // Next-state for TID, TCFG, the countdown and the interrupt flag
  always_comb begin
    tid_d  = wr_tid  ? csr_masked_wr(tid_q,  csr_wr_mask, csr_wr_value) : tid_q;
    tcfg_d = wr_tcfg ? csr_masked_wr(tcfg_q, csr_wr_mask, csr_wr_value) : tcfg_q;
    tval_d = tval_q;
    if (wr_tcfg) begin
      // Any TCFG write restarts the count from the freshly written InitVal
      tval_d = {tcfg_d[31:TCFG_INITVAL_LSB], 2'b00};
    end else if (tcfg_en && (tval_q != 32'hFFFF_FFFF)) begin
      if ((tval_q == 32'h0) && tcfg_periodic) begin
        tval_d = {tcfg_q[31:TCFG_INITVAL_LSB], 2'b00};
      end else begin
        // One-shot underflows 0 -> all-ones, which then parks the counter
        tval_d = tval_q - 32'd1;
      end
    end
    tint_d = tint_set | (tint_q & ~tint_clr);
  end

  // Timer state registers with async reset to architectural defaults
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tid_q  <= CORE_ID;
      tcfg_q <= '0;
      tval_q <= 32'hFFFF_FFFF;
      tint_q <= 1'b0;
    end else begin
      tid_q  <= tid_d;
      tcfg_q <= tcfg_d;
      tval_q <= tval_d;
      tint_q <= tint_d;
    end
  end

  // Hit-qualified read mux; zero on miss so csr can OR it in
  always_comb begin
    csr_rd_hit   = 1'b1;
    csr_rd_value = 32'h0;
    case (csr_rd_num)
      CSR_TID:   csr_rd_value = tid_q;
      CSR_TCFG:  csr_rd_value = tcfg_q;
      CSR_TVAL:  csr_rd_value = tval_q;
      CSR_TICLR: csr_rd_value = 32'h0;
      default:   csr_rd_hit   = 1'b0;
    endcase
  end

  assign timer_int = tint_q;

  stable_counter u_cnt (
    .clk    (clk),
    .resetn (resetn),
    .cnt_lo (cnt_lo),
    .cnt_hi (cnt_hi)
  );

endmodule

// File: tb/tb_csr_timer.sv
// Randomized + directed bench for csr_timer with a queue-based scoreboard.
// The reference model derives TVAL from elapsed cycles since the last TCFG write.
// A separate monitor pops one expectation per cycle and compares all outputs.
module tb_csr_timer;

  localparam logic [31:0] CORE_ID = 32'hC0DE_0003;
  localparam logic [13:0] A_TID   = 14'h040;
  localparam logic [13:0] A_TCFG  = 14'h041;
  localparam logic [13:0] A_TVAL  = 14'h042;
  localparam logic [13:0] A_TICLR = 14'h044;
  localparam logic [13:0] A_SAVE0 = 14'h030;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        csr_we = 1'b0;
  logic [13:0] csr_wr_num = '0;
  logic [31:0] csr_wr_mask = '0;
  logic [31:0] csr_wr_value = '0;
  logic [13:0] csr_rd_num = '0;
  logic        csr_rd_hit;
  logic [31:0] csr_rd_value;
  logic        timer_int;
  logic [31:0] cnt_lo;
  logic [31:0] cnt_hi;

  csr_timer #(.CORE_ID(CORE_ID)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .csr_we       (csr_we),
    .csr_wr_num   (csr_wr_num),
    .csr_wr_mask  (csr_wr_mask),
    .csr_wr_value (csr_wr_value),
    .csr_rd_num   (csr_rd_num),
    .csr_rd_hit   (csr_rd_hit),
    .csr_rd_value (csr_rd_value),
    .timer_int    (timer_int),
    .cnt_lo       (cnt_lo),
    .cnt_hi       (cnt_hi)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        hit;
    logic [31:0] rd;
    logic        tint;
    logic [63:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // ---------------- reference model ----------------
  logic [31:0] m_tid;
  logic [31:0] m_tcfg;
  logic        m_written;   // a TCFG write has happened since reset
  longint      m_age;       // cycles elapsed since the cycle after that write
  logic        m_tint;
  logic [63:0] m_cnt;

  function automatic void model_reset();
    m_tid = CORE_ID; m_tcfg = '0; m_written = 1'b0; m_age = 0;
    m_tint = 1'b0; m_cnt = '0;
  endfunction

  // Timer value as a closed-form function of time since the last TCFG write
  function automatic logic [31:0] m_tval();
    longint kv;
    if (!m_written) return 32'hFFFF_FFFF;
    kv = longint'({m_tcfg[31:2], 2'b00});
    if (!m_tcfg[0]) return 32'(kv);
    if (m_tcfg[1]) return 32'(kv - (m_age % (kv + 1)));
    if (m_age <= kv) return 32'(kv - m_age);
    return 32'hFFFF_FFFF;
  endfunction

  function automatic void model_step(input logic we, input logic [13:0] wn,
                                     input logic [31:0] wm, input logic [31:0] wv);
    logic [31:0] tv;
    tv = m_tval();
    if (we && wn == A_TICLR && wm[0] && wv[0]) m_tint = 1'b0;
    if (m_tcfg[0] && tv == 32'h0) m_tint = 1'b1;
    if (m_written) m_age++;
    if (we && wn == A_TCFG) begin
      m_tcfg = (wm & wv) | (~wm & m_tcfg);
      m_written = 1'b1;
      m_age = 0;
    end
    if (we && wn == A_TID) m_tid = (wm & wv) | (~wm & m_tid);
    m_cnt = m_cnt + 64'd1;
  endfunction

  function automatic exp_t expect_now(input logic [13:0] rn);
    exp_t e;
    e.hit = 1'b1; e.rd = 32'h0;
    e.tint = m_tint; e.cnt = m_cnt;
    if (rn == A_TID) e.rd = m_tid;
    else if (rn == A_TCFG) e.rd = m_tcfg;
    else if (rn == A_TVAL) e.rd = m_tval();
    else if (rn == A_TICLR) e.rd = 32'h0;
    else e.hit = 1'b0;
    return e;
  endfunction

  // ---------------- driver ----------------
  task automatic tick(input logic we, input logic [13:0] wn, input logic [31:0] wm,
                      input logic [31:0] wv, input logic [13:0] rn);
    @(negedge clk);
    csr_we = we; csr_wr_num = wn; csr_wr_mask = wm; csr_wr_value = wv; csr_rd_num = rn;
    exp_q.push_back(expect_now(rn));
    if (resetn) model_step(we, wn, wm, wv);
  endtask

  task automatic idle(input int n, input logic [13:0] rn);
    for (int i = 0; i < n; i++) tick(1'b0, 14'h0, 32'h0, 32'h0, rn);
  endtask

  // Reset-state reads while held in reset, then release in step with the model
  task automatic reset_reads_and_release();
    tick(1'b0, 14'h0, 32'h0, 32'h0, A_TVAL);
    tick(1'b0, 14'h0, 32'h0, 32'h0, A_TCFG);
    tick(1'b0, 14'h0, 32'h0, 32'h0, A_TID);
    resetn = 1'b1;
    model_step(1'b0, 14'h0, 32'h0, 32'h0);
  endtask

  // Called right after a tick: overwrite the counter between monitor sample and edge
  task automatic force_cnt(input logic [63:0] v);
    #3;
    force dut.u_cnt.cnt_q = v;
    #1;
    release dut.u_cnt.cnt_q;
    m_cnt = v + 64'd1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, req, $time);
  endfunction

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rd_hit",    64'(csr_rd_hit),   64'(e.hit));
        chk("rd_value",  64'(csr_rd_value), 64'(e.rd));
        chk("timer_int", 64'(timer_int),    64'(e.tint));
        chk("stable_cnt", {cnt_hi, cnt_lo}, e.cnt);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [13:0] addrs [6];
    logic [13:0] wn, rn;
    logic [31:0] wm, wv;
    logic        we;
    int          waited;
    addrs = '{A_TID, A_TCFG, A_TVAL, A_TICLR, A_SAVE0, A_TCFG};

    model_reset();
    reset_reads_and_release();
    idle(3, A_TVAL);

    // Reset while a periodic count and pending interrupt are live
    tick(1'b1, A_TCFG, 32'hFFFF_FFFF, 32'h0000_0007, A_TVAL);
    idle(7, A_TVAL);
    #3;
    resetn = 1'b0;
    model_reset();
    reset_reads_and_release();
    idle(2, A_TVAL);

    // One-shot: InitVal=2, count 8..0, then park at all-ones
    tick(1'b1, A_TCFG, 32'hFFFF_FFFF, 32'h0000_0009, A_TVAL);
    idle(14, A_TVAL);

    // Periodic: InitVal=1, period 5, clear and re-assert
    tick(1'b1, A_TCFG, 32'hFFFF_FFFF, 32'h0000_0007, A_TVAL);
    idle(7, A_TVAL);
    tick(1'b1, A_TICLR, 32'hFFFF_FFFF, 32'h0000_0001, A_TVAL);
    idle(8, A_TVAL);

    // Set/clear collision: clear lands exactly when TVAL==0
    tick(1'b1, A_TCFG, 32'hFFFF_FFFF, 32'h0000_0007, A_TVAL);
    tick(1'b1, A_TICLR, 32'hFFFF_FFFF, 32'h0000_0001, A_TVAL);
    idle(3, A_TVAL);
    tick(1'b1, A_TICLR, 32'hFFFF_FFFF, 32'h0000_0001, A_TVAL);
    idle(2, A_TVAL);

    // Masked writes, read-only TVAL, miss address
    tick(1'b1, A_TCFG, 32'hFFFF_FFFF, 32'h0000_0000, A_TVAL);
    tick(1'b1, A_TID, 32'hFFFF_FFFF, 32'h0000_0000, A_TID);
    tick(1'b1, A_TID, 32'h0000_FF00, 32'hFFFF_FFFF, A_TID);
    tick(1'b1, A_TVAL, 32'hFFFF_FFFF, 32'h0000_1234, A_TID);
    tick(1'b0, 14'h0, 32'h0, 32'h0, A_TVAL);
    tick(1'b0, 14'h0, 32'h0, 32'h0, A_SAVE0);
    tick(1'b0, 14'h0, 32'h0, 32'h0, A_TICLR);

    // Stable counter carry into the high half, then full 64-bit wrap
    force_cnt(64'h0000_0000_FFFF_FFFF);
    idle(2, A_TVAL);
    force_cnt(64'hFFFF_FFFF_FFFF_FFFF);
    idle(2, A_TVAL);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      wn = addrs[$urandom_range(0, 5)];
      rn = addrs[$urandom_range(0, 5)];
      we = ($urandom_range(0, 2) != 0);
      wm = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : $urandom;
      wv = $urandom;
      if (wn == A_TCFG && $urandom_range(0, 4) != 0) wv = wv & 32'h0000_001F;
      tick(we, wn, wm, wv, rn);
    end
    idle(2, A_TVAL);

    // Drain the scoreboard with a bounded wait
    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    #4;
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/csr_timer.md
# csr_timer

Constant-timer and stable-counter unit for the CPU's CSR file. Owns the TID, TCFG, TVAL and TICLR registers and the 64-bit stable counter. Produces the timer interrupt pending bit that the `csr` block reflects as ESTAT.IS[11], and the counter halves consumed by `rdcntvl.w`/`rdcntvh.w` in the execute stage. CSR writes arrive on the same write bus the `csr` block uses; reads are returned through a hit-qualified mux output that `csr` ORs into its own read value.

## Interface
Parameters:
- `CORE_ID`, default 32'h0: reset value of TID.

Ports:
- One clock; reset is asynchronous and active-low.
- `clk`  in  1  sole clock, rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `csr_we`  in  1  CSR write strobe (WB stage, already exception-qualified).
- `csr_wr_num`  in  14  CSR write address.
- `csr_wr_mask`  in  32  per-bit write mask.
- `csr_wr_value`  in  32  write data.
- `csr_rd_num`  in  14  CSR read address.
- `csr_rd_hit`  out  1  `csr_rd_num` addresses TID, TCFG, TVAL or TICLR.
- `csr_rd_value`  out  32  read data; 0 when `csr_rd_hit`=0.
- `timer_int`  out  1  timer interrupt pending (ESTAT.IS[11]).
- `cnt_lo`  out  32  stable counter [31:0].
- `cnt_hi`  out  32  stable counter [63:32].

## Operation
- Addresses: TID 0x40, TCFG 0x41, TVAL 0x42, TICLR 0x44.
- Masked write: `new = mask & value | ~mask & old`, applied per field.
- TCFG fields: En [0], Periodic [1], InitVal [31:2]. All bits writable.
- TID: 32-bit, fully writable. Reads return the register.
- TVAL (`timer_cnt`) is read-only. Writes to 0x42 are ignored.
- TICLR reads 0. A write with `mask[0] & value[0]` clears `timer_int`. Other bits have no effect.
- Per-cycle `timer_cnt` update, priority high to low:
  - TCFG write: `timer_cnt <= {new InitVal, 2'b00}`.
  - Else if En and `timer_cnt != 32'hFFFF_FFFF`:
    - `timer_cnt==0` and Periodic: reload `{InitVal, 2'b00}`.
    - Otherwise: `timer_cnt - 1`.
  - Else: hold.
- One-shot mode: the count goes 0 → 0xFFFF_FFFF and then stops.
- `timer_int` set condition: En=1 and `timer_cnt==0` (old values) sets it on the next edge.
- `timer_int` clear: TICLR clear clears it.
- `timer_int` simultaneous set and clear: set wins.
- Stable counter: free-running +1 every cycle. Wraps 2^64−1 → 0 and is not writable.
- Reset values:
  - TCFG = 0.
  - `timer_cnt` = 32'hFFFF_FFFF.
  - `timer_int` = 0.
  - TID = `CORE_ID`.
  - Stable counter = 0.
  - Therefore `cnt_lo` = `cnt_hi` = 0.
- Reset mid-count: asynchronous assertion zeroes/restores all state immediately. No pending interrupt survives.

## Timing
- All state is registered on `clk`.
- `csr_rd_value` and `csr_rd_hit` are combinational from `csr_rd_num` and current state. No read latency.
- A write is visible on the read path the cycle after `csr_we`.
- TCFG write at cycle N with InitVal=k, En=1:
  - TVAL=4k at N+1.
  - TVAL reaches 0 at N+1+4k.
  - `timer_int`=1 at N+2+4k.
- The periodic period is 4k+1 cycles, counted from one 0 to the next.
- `cnt_hi` and `cnt_lo` come from the same register, so they are coherent within a cycle.

## Structure
- Shared package `csr_defs`: CSR number constants (TID/TCFG/TVAL/TICLR plus the existing CRMD…SAVE3), TCFG field bit positions, and TICLR_CLR bit index. `csr` imports the same package.
- Sub-module `stable_counter`: 64-bit free-running counter with async active-low reset, outputs lo/hi.
- The rest is flat in `csr_timer`.

## Test plan
- Reset:
  - Stimulus: hold `resetn`=0 mid-count, then release.
  - Required response: TVAL reads 0xFFFF_FFFF, TCFG 0, TID = `CORE_ID`, `timer_int`=0, `cnt_lo`=0, `cnt_hi`=0.
- One-shot:
  - Stimulus: write TCFG=0x0000_0009 (InitVal=2, En=1, Periodic=0).
  - Required response: TVAL follows 8,7,…,0. `timer_int` rises the cycle after 0. TVAL becomes 0xFFFF_FFFF and holds.
- Periodic:
  - Stimulus: write TCFG=0x0000_0007 (InitVal=1, En=1, Periodic=1).
  - Required response: TVAL cycles 4,3,2,1,0,4,… After a TICLR write of value 1, `timer_int` clears and re-asserts 5 cycles after the previous assertion.
- Set/clear collision:
  - Stimulus: TICLR write with value 1 in the exact cycle TVAL==0 with En=1.
  - Required response: `timer_int` stays 1.
- Masked writes:
  - Stimulus: TID write value 0xFFFF_FFFF, mask 0x0000_FF00 over TID=0; then a write of 0x1234 to TVAL.
  - Required response: TID reads 0x0000_FF00. TVAL is unchanged. `csr_rd_hit`=0 for address 0x30.
- Stable counter wrap:
  - Stimulus: force counter to 0x0000_0000_FFFF_FFFF.
  - Required response: next cycle `cnt_hi`=1, `cnt_lo`=0. From 2^64−1 it wraps to 0.
